// File: rtl/fpdiv_pkg.sv
// ---------------------------------------------------------------------------
// fpdiv_pkg
// Shared types and constants for the sign-magnitude fixed-point divider.
//   round_mode_t : rounding mode encoding carried on round_in
//   div_state_t  : controller states of fpdiv
//   OOR_*        : bit positions inside the 4-bit status word oor_out
//   round_up()   : decides whether the truncated magnitude is bumped by one
// ---------------------------------------------------------------------------
package fpdiv_pkg;

    typedef enum logic [1:0] {
        RND_ZERO    = 2'b00,
        RND_NEAREST = 2'b01,
        RND_POS     = 2'b10,
        RND_NEG     = 2'b11
    } round_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        ROUND = 2'b10,
        DONE  = 2'b11
    } div_state_t;

    localparam int OOR_DBZ = 0;  // divisor magnitude was zero
    localparam int OOR_OVF = 1;  // result saturated
    localparam int OOR_UNF = 2;  // nonzero true quotient rounded to zero
    localparam int OOR_INX = 3;  // discarded bits were nonzero

    // Magnitude increment decision. lsb is the kept LSB (ties-to-even),
    // sign selects the direction for the directed modes since the
    // magnitude moves away from zero when incremented.
    function automatic logic round_up(
        input round_mode_t mode,
        input logic        guard,
        input logic        sticky,
        input logic        lsb,
        input logic        sign
    );
        logic inc;
        inc = 1'b0;
        case (mode)
            RND_ZERO:    inc = 1'b0;
            RND_NEAREST: inc = guard & (sticky | lsb);
            RND_POS:     inc = (guard | sticky) & ~sign;
            RND_NEG:     inc = (guard | sticky) & sign;
            default:     inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fracdiv.sv
// ---------------------------------------------------------------------------
// fracdiv
// Unsigned restoring shift-subtract divider core, one quotient bit per
// iterate cycle, MSB first. The dividend is extended by one zero LSB so
// that DW+1 iterations yield DW quotient bits plus one guard bit.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   load           : capture dividend/divisor, clear remainder and quotient
//   iterate        : perform one shift-subtract step
//   dividend       : DW-bit unsigned dividend
//   divisor        : VW-bit unsigned divisor
//   quotient       : DW-bit truncated quotient
//   guard          : first quotient bit below the LSB
//   sticky         : final remainder is nonzero
//   done           : high during the iterate cycle that produces the guard
//                    bit, so the controller can leave on the same edge
// ---------------------------------------------------------------------------
module fracdiv
    import fpdiv_pkg::*;
#(
    parameter int DW = 23,
    parameter int VW = 15
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          load,
    input  logic          iterate,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic          guard,
    output logic          sticky,
    output logic          done
);
    localparam int CW = $clog2(DW + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(DW);

    logic [DW:0]   dvd_q, dvd_d;   // dividend bits still to be brought down
    logic [DW:0]   quo_q, quo_d;   // quotient bits, guard ends up in bit 0
    logic [VW-1:0] rem_q, rem_d;   // partial remainder, always < divisor
    logic [VW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [VW:0] rem_shift;
    logic [VW:0] trial;

    always_comb begin
        dvd_d = dvd_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;

        rem_shift = {rem_q, dvd_q[DW]};
        // rem_shift < 2*divisor, so the top bit of the difference is a
        // reliable borrow flag.
        trial     = rem_shift - {1'b0, dvs_q};

        if (load) begin
            dvd_d = {dividend, 1'b0};
            quo_d = '0;
            rem_d = '0;
            dvs_d = divisor;
            cnt_d = '0;
        end else if (iterate) begin
            dvd_d = {dvd_q[DW-1:0], 1'b0};
            if (!trial[VW]) begin
                rem_d = trial[VW-1:0];
                quo_d = {quo_q[DW-1:0], 1'b1};
            end else begin
                rem_d = rem_shift[VW-1:0];
                quo_d = {quo_q[DW-1:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dvd_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            dvd_q <= dvd_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient = quo_q[DW:1];
    assign guard    = quo_q[0];
    assign sticky   = |rem_q;
    assign done     = iterate && (cnt_q == LAST_CNT);

endmodule

// File: rtl/fpdiv.sv
// ---------------------------------------------------------------------------
// fpdiv
// Sequential signed fixed-point divider, sign-magnitude format with P
// integer bits (sign included) and Q fraction bits. A restoring core
// (fracdiv) produces the magnitude one bit per cycle, then one cycle of
// rounding, saturation and status flag generation.
// Ports:
//   clk_in    : clock, rising edge
//   rst_in    : asynchronous active-high reset
//   x_in      : dividend, x_in[N-1] is the sign
//   y_in      : divisor,  y_in[N-1] is the sign
//   round_in  : 00 toward zero, 01 nearest-even, 10 toward +inf, 11 -inf
//   start_in  : start request, accepted while ready_out is high
//   q_out     : quotient, q_out[N-1] is the sign
//   oor_out   : [0] div-by-zero [1] overflow [2] underflow [3] inexact
//   valid_out : q_out/oor_out hold a finished result
//   ready_out : a start request will be accepted
// Build option:
//   FPDIV_EARLY_EXIT_EN : a zero dividend or divisor skips the iterative
//                         phase and goes straight to rounding.
// ---------------------------------------------------------------------------
module fpdiv
    import fpdiv_pkg::*;
#(
    parameter int P = 8,
    parameter int Q = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [P+Q-1:0]   x_in,
    input  logic [P+Q-1:0]   y_in,
    input  logic [1:0]       round_in,
    input  logic             start_in,
    output logic [P+Q-1:0]   q_out,
    output logic [3:0]       oor_out,
    output logic             valid_out,
    output logic             ready_out
);
    localparam int N = P + Q;
    localparam int W = N - 1 + Q;
    localparam logic [N-2:0] MAG_MAX = '1;

    div_state_t   state_q, state_d;
    logic         sign_q, sign_d;
    round_mode_t  mode_q, mode_d;
    logic         x_zero_q, x_zero_d;
    logic         y_zero_q, y_zero_d;
    logic [N-1:0] q_q, q_d;
    logic [3:0]   oor_q, oor_d;

    logic         core_load;
    logic         core_iterate;
    logic [W-1:0] core_quotient;
    logic         core_guard;
    logic         core_sticky;
    logic         core_done;

    logic         x_zero_in;
    logic         y_zero_in;
    logic         inc;
    logic [W:0]   mag_sum;
    logic         ovf;
    logic [N-2:0] mag_res;
    logic [N-1:0] res_q;
    logic [3:0]   res_oor;

    // Sign bits are ignored here so that -0 behaves exactly like +0.
    assign x_zero_in = (x_in[N-2:0] == '0);
    assign y_zero_in = (y_in[N-2:0] == '0);

    fracdiv #(
        .DW (W),
        .VW (N - 1)
    ) u_core (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .load     (core_load),
        .iterate  (core_iterate),
        .dividend ({x_in[N-2:0], {Q{1'b0}}}),
        .divisor  (y_in[N-2:0]),
        .quotient (core_quotient),
        .guard    (core_guard),
        .sticky   (core_sticky),
        .done     (core_done)
    );

    // Rounding, saturation and flags from the finished core state.
    always_comb begin
        inc     = round_up(mode_q, core_guard, core_sticky, core_quotient[0], sign_q);
        mag_sum = {1'b0, core_quotient} + {{W{1'b0}}, inc};
        // Any bit above the N-1 magnitude bits means the value does not fit;
        // this covers both a too-large quotient and a rounding carry-out.
        ovf     = |mag_sum[W:N-1];
        mag_res = ovf ? MAG_MAX : mag_sum[N-2:0];
        res_q   = '0;
        res_oor = '0;

        if (y_zero_q) begin
            res_oor[OOR_DBZ] = 1'b1;
            if (!x_zero_q) begin
                res_q            = {sign_q, MAG_MAX};
                res_oor[OOR_OVF] = 1'b1;
            end
        end else if (!x_zero_q) begin
            // A zero magnitude is always reported as +0.
            res_q[N-1]       = sign_q & (mag_res != '0);
            res_q[N-2:0]     = mag_res;
            res_oor[OOR_OVF] = ovf;
            res_oor[OOR_UNF] = (mag_res == '0);
            res_oor[OOR_INX] = core_guard | core_sticky;
        end
    end

    // Controller next state.
    always_comb begin
        state_d      = state_q;
        sign_d       = sign_q;
        mode_d       = mode_q;
        x_zero_d     = x_zero_q;
        y_zero_d     = y_zero_q;
        q_d          = q_q;
        oor_d        = oor_q;
        core_load    = 1'b0;
        core_iterate = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_in) begin
                    sign_d    = x_in[N-1] ^ y_in[N-1];
                    mode_d    = round_mode_t'(round_in);
                    x_zero_d  = x_zero_in;
                    y_zero_d  = y_zero_in;
                    core_load = 1'b1;
`ifdef FPDIV_EARLY_EXIT_EN
                    // The result of a zero operand does not depend on the
                    // core, so the iterative phase can be skipped.
                    state_d   = (x_zero_in || y_zero_in) ? ROUND : CALC;
`else
                    state_d   = CALC;
`endif
                end
            end
            CALC: begin
                core_iterate = 1'b1;
                if (core_done) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                q_d     = res_q;
                oor_d   = res_oor;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mode_q   <= RND_ZERO;
            x_zero_q <= 1'b0;
            y_zero_q <= 1'b0;
            q_q      <= '0;
            oor_q    <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mode_q   <= mode_d;
            x_zero_q <= x_zero_d;
            y_zero_q <= y_zero_d;
            q_q      <= q_d;
            oor_q    <= oor_d;
        end
    end

    assign q_out     = q_q;
    assign oor_out   = oor_q;
    assign valid_out = (state_q == DONE);
    assign ready_out = (state_q == IDLE) || (state_q == DONE);

endmodule

// File: tb/tb_fpdiv.sv
`timescale 1ns/1ps
module tb_fpdiv;
    localparam int P   = 8;
    localparam int Q   = 8;
    localparam int N   = P + Q;
    localparam int LAT = P + 2 * Q + 1;
    localparam int TMO = 200;

    logic         clk_in   = 1'b0;
    logic         rst_in   = 1'b0;
    logic [N-1:0] x_in     = '0;
    logic [N-1:0] y_in     = '0;
    logic [1:0]   round_in = '0;
    logic         start_in = 1'b0;
    logic [N-1:0] q_out;
    logic [3:0]   oor_out;
    logic         valid_out;
    logic         ready_out;

    int n_cmp  = 0;
    int n_fail = 0;

    fpdiv #(.P(P), .Q(Q)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .round_in  (round_in),
        .start_in  (start_in),
        .q_out     (q_out),
        .oor_out   (oor_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer division of |x|*2^(Q+1) by |y| gives the
    // truncated quotient with one extra (guard) bit; remainder gives sticky.
    function automatic void model(input logic [N-1:0] x, input logic [N-1:0] y,
                                  input logic [1:0] m,
                                  output logic [N-1:0] q, output logic [3:0] f);
        longint ax, ay, num, qf, mag, lim;
        logic   s, g, st, inc, ovf;
        ax  = longint'(x[N-2:0]);
        ay  = longint'(y[N-2:0]);
        s   = x[N-1] ^ y[N-1];
        lim = (longint'(1) << (N - 1)) - 1;
        q   = '0;
        f   = '0;
        if (ay == 0) begin
            if (ax == 0) begin
                f = 4'b0001;
            end else begin
                q = {s, lim[N-2:0]};
                f = 4'b0011;
            end
        end else if (ax != 0) begin
            num = ax * (longint'(1) << (Q + 1));
            qf  = num / ay;
            st  = (num % ay) != 0;
            g   = qf[0];
            mag = qf / 2;
            case (m)
                2'b00:   inc = 1'b0;
                2'b01:   inc = g && (st || mag[0]);
                2'b10:   inc = (g || st) && !s;
                default: inc = (g || st) && s;
            endcase
            if (inc) mag = mag + 1;
            ovf = mag > lim;
            if (ovf) mag = lim;
            f = {g | st, mag == 0, ovf, 1'b0};
            q = (mag == 0) ? '0 : {s, mag[N-2:0]};
        end
    endfunction

    // Drive a request and return right after the accept edge (e0) + 1ns.
    task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic [1:0] m);
        @(posedge clk_in);
        #1;
        x_in     = x;
        y_in     = y;
        round_in = m;
        start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        x_in     = $urandom;
        y_in     = $urandom;
        round_in = 2'($urandom);
    endtask

    task automatic wait_valid(input int from, output int cyc);
        cyc = from;
        while (!valid_out && cyc < TMO) begin
            @(posedge clk_in);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [1:0] m, input logic [N-1:0] eq, input logic [3:0] ef);
        int cyc;
        start_op(x, y, m);
        chk({tag, "/valid_drop"}, 32'(valid_out), 32'd0);
        wait_valid(0, cyc);
        $display("op %s x=%h y=%h m=%0d q=%h oor=%b lat=%0d", tag, x, y, m, q_out, oor_out, cyc);
        chk({tag, "/lat"}, 32'(cyc), 32'(LAT));
        chk({tag, "/q"},   32'(q_out), 32'(eq));
        chk({tag, "/oor"}, 32'(oor_out), 32'(ef));
    endtask

    task automatic run_model(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                             input logic [1:0] m);
        logic [N-1:0] eq;
        logic [3:0]   ef;
        model(x, y, m, eq, ef);
        run_op(tag, x, y, m, eq, ef);
    endtask

    initial begin
        int cyc;
        logic [N-1:0] rx, ry;

        // Reset
        #2 rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst/ready", 32'(ready_out), 32'd1);
        chk("rst/valid", 32'(valid_out), 32'd0);
        chk("rst/q",     32'(q_out),     32'd0);
        chk("rst/oor",   32'(oor_out),   32'd0);
        rst_in = 1'b0;

        // Directed cases with hand-derived results
        run_op("exact",      16'h0300, 16'h0180, 2'b01, 16'h0200, 4'b0000);
        run_op("third_ne",   16'h0100, 16'h0300, 2'b01, 16'h0055, 4'b1000);
        run_op("third_pos",  16'h0100, 16'h0300, 2'b10, 16'h0056, 4'b1000);
        run_op("nthird_neg", 16'h8100, 16'h0300, 2'b11, 16'h8056, 4'b1000);
        run_op("nthird_pos", 16'h8100, 16'h0300, 2'b10, 16'h8055, 4'b1000);
        run_op("third_zero", 16'h0100, 16'h0300, 2'b00, 16'h0055, 4'b1000);
        run_op("dbz",        16'h0200, 16'h0000, 2'b01, 16'h7FFF, 4'b0011);
        run_op("dbz_neg",    16'h8200, 16'h0000, 2'b00, 16'hFFFF, 4'b0011);
        run_op("zero_zero",  16'h0000, 16'h0000, 2'b01, 16'h0000, 4'b0001);
        run_op("nz_nz",      16'h8000, 16'h8000, 2'b10, 16'h0000, 4'b0001);
        run_op("zero_div",   16'h0000, 16'h0300, 2'b10, 16'h0000, 4'b0000);
        run_op("negzero",    16'h8000, 16'h0100, 2'b11, 16'h0000, 4'b0000);
        run_op("ovf",        16'h7F00, 16'h0001, 2'b01, 16'h7FFF, 4'b0010);
        run_op("ovf_neg",    16'h7F00, 16'h8001, 2'b00, 16'hFFFF, 4'b0010);
        run_op("unf_zero",   16'h0001, 16'h7F00, 2'b00, 16'h0000, 4'b1100);
        run_op("unf_pos",    16'h0001, 16'h7F00, 2'b10, 16'h0001, 4'b1000);
        run_op("unf_negpos", 16'h8001, 16'h7F00, 2'b10, 16'h0000, 4'b1100);
        run_op("rnd_carry",  16'h7FFF, 16'h0101, 2'b10, 16'h7F80, 4'b1000);

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom) >> $urandom_range(0, 15);
            run_model("rnd", rx, ry, 2'($urandom_range(0, 3)));
        end

        // start_in during CALC must not disturb the running division
        start_op(16'h0100, 16'h0300, 2'b01);
        repeat (5) @(posedge clk_in);
        #1;
        x_in     = 16'h7F00;
        y_in     = 16'h0001;
        start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        wait_valid(6, cyc);
        $display("op calc_start q=%h oor=%b lat=%0d", q_out, oor_out, cyc);
        chk("calc_start/lat", 32'(cyc), 32'(LAT));
        chk("calc_start/q",   32'(q_out), 32'h0055);
        chk("calc_start/oor", 32'(oor_out), 32'b1000);

        // Back-to-back from DONE
        run_op("b2b", 16'h0300, 16'h0180, 2'b01, 16'h0200, 4'b0000);

        // Asynchronous reset in the middle of CALC
        start_op(16'h0100, 16'h0300, 2'b10);
        repeat (10) @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        $display("op mid_reset ready=%0d valid=%0d q=%h oor=%b", ready_out, valid_out, q_out, oor_out);
        chk("mid_rst/ready", 32'(ready_out), 32'd1);
        chk("mid_rst/valid", 32'(valid_out), 32'd0);
        chk("mid_rst/q",     32'(q_out),     32'd0);
        chk("mid_rst/oor",   32'(oor_out),   32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        run_op("after_rst", 16'h8100, 16'h0300, 2'b11, 16'h8056, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
